// File: rtl/min_max_finder_param_if.sv
// Bus bundle for the min/max finder: array write port,
// search start, and the search results with state flags.
interface min_max_finder_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              Start;
    logic              Wr_En;
    logic [AW-1:0]     Wr_Addr;
    logic [DATA_W-1:0] Wr_Data;
    logic [DATA_W-1:0] Max;
    logic [DATA_W-1:0] Min;
    logic [AW-1:0]     Max_Idx;
    logic [AW-1:0]     Min_Idx;
    logic              Busy;
    logic              Done;
    logic              Qd;
    logic              Qc;
    logic              Ql;
    logic              Qi;

    modport master (
        output Start, Wr_En, Wr_Addr, Wr_Data,
        input  Max, Min, Max_Idx, Min_Idx,
        input  Busy, Done, Qd, Qc, Ql, Qi
    );

    modport slave (
        input  Start, Wr_En, Wr_Addr, Wr_Data,
        output Max, Min, Max_Idx, Min_Idx,
        output Busy, Done, Qd, Qc, Ql, Qi
    );
endinterface

// File: rtl/min_max_finder_param.sv
// Sequential min/max search over a small register array,
// one element per cycle, two comparators, ties keep lowest index.
module min_max_finder_param #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int SIGNED_MODE = 0
) (
    input logic                   Clk,
    input logic                   Reset,
    min_max_finder_param_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   LIM  = (AW + 1)'(DEPTH);

    typedef enum logic [3:0] {
        INI  = 4'b0001,
        LOAD = 4'b0010,
        COMP = 4'b0100,
        DONE = 4'b1000
    } state_t;

    state_t            state;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] min_q;
    logic [AW-1:0]     max_idx_q;
    logic [AW-1:0]     min_idx_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] cur;

    function automatic logic gt(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        if (SIGNED_MODE != 0)
            gt = $signed(a) > $signed(b);
        else
            gt = a > b;
    endfunction

    assign cur = mem[idx];

    // Array writes: only while idle and only for in-range addresses.
    always_ff @(posedge Clk) begin
        if (state == INI && bus.Wr_En && {1'b0, bus.Wr_Addr} < LIM)
            mem[bus.Wr_Addr] <= bus.Wr_Data;
    end

    // Search FSM with registered results and status flags.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= INI;
            idx       <= '0;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (1'b1)
                state[0]: begin
                    idx    <= '0;
                    done_q <= 1'b0;
                    if (bus.Start) begin
                        state  <= LOAD;
                        busy_q <= 1'b1;
                    end
                end
                state[1]: begin
                    max_q     <= mem[0];
                    min_q     <= mem[0];
                    max_idx_q <= '0;
                    min_idx_q <= '0;
                    idx       <= AW'(1);
                    if (DEPTH == 1) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state <= COMP;
                    end
                end
                state[2]: begin
                    if (gt(cur, max_q)) begin
                        max_q     <= cur;
                        max_idx_q <= idx;
                    end
                    if (gt(min_q, cur)) begin
                        min_q     <= cur;
                        min_idx_q <= idx;
                    end
                    if (idx == LAST) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                state[3]: begin
                    done_q <= 1'b0;
                    state  <= INI;
                end
                default: begin
                    state  <= INI;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Max     = max_q;
    assign bus.Min     = min_q;
    assign bus.Max_Idx = max_idx_q;
    assign bus.Min_Idx = min_idx_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.Qi      = state[0];
    assign bus.Ql      = state[1];
    assign bus.Qc      = state[2];
    assign bus.Qd      = state[3];
endmodule

// File: doc/min_max_finder_param.md
MIN_MAX_FINDER_PARAM -- requirements
Module: min_max_finder_param

Interface
- REQ-001: Parameter DATA_W, default 8: element width in bits, legal range 2..32.
- REQ-002: Parameter DEPTH, default 16: number of array elements, legal range 1..256.
- REQ-003: Parameter SIGNED_MODE, default 0: 0 compares elements as unsigned, 1 compares them as two's-complement.
- REQ-004: Derived AW = max(1, ceil(log2(DEPTH))), used as the address and index width.
- REQ-005: Clk  input  1  rising-edge clock.
- REQ-006: Reset  input  1  reset; asynchronous, active-high.
- REQ-007: Start  input  1  begin a search; sampled only in state INI.
- REQ-008: Wr_En  input  1  array write strobe.
- REQ-009: Wr_Addr  input  AW  array write address.
- REQ-010: Wr_Data  input  DATA_W  array write data.
- REQ-011: Max  output  DATA_W  largest element found.
- REQ-012: Min  output  DATA_W  smallest element found.
- REQ-013: Max_Idx  output  AW  index of Max.
- REQ-014: Min_Idx  output  AW  index of Min.
- REQ-015: Busy  output  1  high in LOAD and COMP.
- REQ-016: Done  output  1  high for exactly one cycle, in state DONE.
- REQ-017: {Qd, Qc, Ql, Qi}  output  4  one-hot state bits for DONE, COMP, LOAD and INI.

Function
- REQ-018: The block SHALL hold an internal DEPTH x DATA_W register array M, with a synchronous write M[Wr_Addr] <= Wr_Data on every edge where Wr_En=1 and the state is INI.
- REQ-019: Wr_En SHALL be ignored outside INI.
- REQ-020: Wr_En with Wr_Addr >= DEPTH SHALL be ignored.
- REQ-021: The FSM SHALL have the states INI, LOAD, COMP and DONE, one-hot encoded.
- REQ-022: INI: I <= 0; go to LOAD if Start=1, else stay in INI.
- REQ-023: LOAD: Max <= M[0], Min <= M[0], Max_Idx <= 0, Min_Idx <= 0, I <= 1; go to DONE if DEPTH=1, else go to COMP.
- REQ-024: COMP: the block SHALL compare M[I] against both Max and Min in the same cycle, using two comparators, and evaluate one element per cycle.
- REQ-025: COMP update rule: if M[I] > Max, then Max <= M[I] and Max_Idx <= I.
- REQ-026: COMP update rule: if M[I] < Min, then Min <= M[I] and Min_Idx <= I.
- REQ-027: COMP comparisons SHALL be strict, so ties keep the lowest index.
- REQ-028: COMP: if I = DEPTH-1, go to DONE; else I <= I+1 and stay in COMP.
- REQ-029: DONE: assert Done and go to INI unconditionally.
- REQ-030: Latency SHALL be DEPTH+1 cycles from the edge that samples Start to the Done cycle, inclusive of LOAD and COMP; for DEPTH=16 that is LOAD + 15 COMP + DONE.
- REQ-031: Max, Min, Max_Idx and Min_Idx SHALL hold their values from DONE until the next LOAD.
- REQ-032: Start outside INI SHALL be ignored; no queuing, no restart.
- REQ-033: Start=1 continuously SHALL re-launch a search every DEPTH+2 cycles (INI is visited for one cycle).
- REQ-034: Wr_En and Start in the same INI cycle: the write SHALL complete at that edge, and LOAD/COMP SHALL see the new value.
- REQ-035: In SIGNED_MODE=1, 8'h80 SHALL be treated as the minimum value and 8'h7F as the maximum value.
- REQ-036: The index counter SHALL NOT wrap inside a search; the last index evaluated is DEPTH-1, including when DEPTH is not a power of two.

Reset
- REQ-037: On Reset=1 the block SHALL enter INI immediately, with Max=0, Min=0, Max_Idx=0, Min_Idx=0, I=0, Busy=0 and Done=0.
- REQ-038: Array M SHALL NOT be reset and retains its contents.
- REQ-039: Reset during LOAD or COMP SHALL abort the search, produce no Done pulse and clear the results.
- REQ-040: The first rising edge after Reset deasserts SHALL be treated as an INI cycle.

Verification
- REQ-041: Unsigned, DEPTH=16, M[i]=i*3 for i=0..15, Start pulse -> Done 17 cycles after Start, Max=45, Max_Idx=15, Min=0, Min_Idx=0.
- REQ-042: Unsigned ties, M = {7, 200, 3, 200, 3, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7} -> Max=200, Max_Idx=1, Min=3, Min_Idx=2.
- REQ-043: SIGNED_MODE=1, M[5]=8'h80, M[9]=8'h7F, all other elements 8'h00 -> Min=8'h80, Min_Idx=5, Max=8'h7F, Max_Idx=9; the same data with SIGNED_MODE=0 -> Max=8'h80, Max_Idx=5, Min=8'h00, Min_Idx=0.
- REQ-044: DEPTH=1, M[0]=8'h5A -> states INI, LOAD, DONE; Done on the 2nd cycle after Start; Max=Min=8'h5A.
- REQ-045: Reset asserted in the 4th COMP cycle -> immediate return to INI, outputs 0, no Done; a following Start produces a correct result from the unchanged M.
- REQ-046: Wr_En with M[3] <= 8'hFF issued during COMP -> ignored and the result unchanged; Wr_En together with Start in INI -> the new value is included in the result.
